// File: rtl/hamming_encode_pipe_pkg.sv
// Shared types for the Hamming(7,4) encoder pipeline.
// Pattern, parity and codeword widths plus the codeword bundle.
package hamming_encode_pipe_pkg;

  localparam int PATTERN_WIDTH = 4;
  localparam int PARITY_WIDTH  = 3;

  typedef logic [PATTERN_WIDTH-1:0] pattern_t;
  typedef logic [PARITY_WIDTH-1:0]  parity_t;

  typedef struct packed {
    parity_t  parity;
    pattern_t pattern;
  } codeword_t;

  localparam int CODEWORD_WIDTH = $bits(codeword_t);

endpackage

// File: rtl/hamming_encode_pipe_parity_gen.sv
// Combinational Hamming(7,4) parity generator.
// Ports: i_pattern (data), o_parity ({p3,p2,p1}).
module hamming_parity_gen
  import hamming_encode_pipe_pkg::*;
(
  input  pattern_t i_pattern,
  output parity_t  o_parity
);

  // p1 covers d0,d1,d3; p2 covers d0,d2,d3; p3 covers d1,d2,d3
  assign o_parity[0] = ^(i_pattern & 4'b1011);
  assign o_parity[1] = ^(i_pattern & 4'b1101);
  assign o_parity[2] = ^(i_pattern & 4'b1110);

endmodule

// File: rtl/hamming_encode_pipe.sv
// Registered Hamming encoder stage with a 2-entry output buffer.
// Ports: i_clk, i_rst, i_clear, i_valid/o_ready/i_pattern in,
// o_valid/i_ready/o_codeword out, o_count issued-word counter.
module hamming_encode_pipe
  import hamming_encode_pipe_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  pattern_t             i_pattern,
  output logic                 o_ready,
  output logic                 o_valid,
  output codeword_t            o_codeword,
  input  logic                 i_ready,
  output logic [CNT_WIDTH-1:0] o_count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  parity_t               parity;
  codeword_t             mem_q [DEPTH];
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic                  ready_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  push;
  logic                  pop;

  hamming_parity_gen u_parity (
    .i_pattern (i_pattern),
    .o_parity  (parity)
  );

  assign push = i_valid & ready_q;
  assign pop  = (occ_q != 2'd0) & i_ready;

  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      push && !pop: occ_d = occ_q + 2'd1;
      pop && !push: occ_d = occ_q - 2'd1;
      default:      occ_d = occ_q;
    endcase
  end

  // ready is registered from next occupancy so i_ready
  // never reaches o_ready combinationally
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (i_clear) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ready_q  <= 1'b1;
      count_q  <= '0;
    end else begin
      occ_q   <= occ_d;
      ready_q <= (occ_d != FULL);
      if (push) begin
        mem_q[wr_ptr_q] <= '{
          parity:  parity,
          pattern: i_pattern
        };
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        count_q  <= count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = (occ_q != 2'd0);
  assign o_codeword = mem_q[rd_ptr_q];
  assign o_count    = count_q;

endmodule
